stage_regfile: RTL
==================

// Module: stage_regfile
// PURPOSE
//  - Integer register file x0..x31; responder for the decode stage's two register-read requests.
//  - Accepts one write per cycle from the write-back stage.
//  - Reads are combinational; the write commits on the rising clock edge.
//  - A post-reset sweep zeroes all entries so the storage can map to LUT-RAM (no parallel reset).
// PARAMETERS
//  - NUM_REGS   32  number of architectural registers; x0 hardwired to zero
//  - INIT_FIRST 1   first index swept after reset (x0 never stored)
// PORTS
//  - clk          in   1      rising-edge clock
//  - rst          in   1      reset; synchronous, active-high
//  - we_i         in   1      write enable from write-back (`WriteEnable)
//  - waddr_i      in   5      write address (`RegAddrBus)
//  - wdata_i      in   32     write data (`RegBus)
//  - re1_i        in   1      read-port-1 enable (`ReadEnable)
//  - raddr1_i     in   5      read-port-1 address
//  - rdata1_o     out  32     read-port-1 data
//  - re2_i        in   1      read-port-2 enable
//  - raddr2_i     in   5      read-port-2 address
//  - rdata2_o     out  32     read-port-2 data
//  - init_done_o  out  1      1 = sweep complete, file usable
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is synchronous and active-high.
//    - rst sampled high -> state INIT, sweep_cnt <= INIT_FIRST, init_done_o <= 0.
//    - Read outputs are combinational and equal 0 while rst is high.
//  - FSM INIT (one step per cycle, rst low):
//    - mem[sweep_cnt] <= 0; sweep_cnt += 1.
//    - When the cycle that writes index NUM_REGS-1 completes -> RUN, init_done_o <= 1.
//    - 31 cycles from rst deassert to init_done_o high at defaults.
//    - we_i is ignored in INIT; reads return 0.
//  - FSM RUN:
//    - we_i=1 and waddr_i!=0 -> mem[waddr_i] <= wdata_i at the edge.
//    - A write to x0 is discarded.
//  - Read port n (n = 1, 2), evaluated in priority order:
//    1. rst high or state INIT -> 0.
//    2. re_n=0 -> 0.
//    3. raddr_n=0 -> 0.
//    4. Bypass hit (only when the optional feature is compiled in) -> wdata_i.
//    5. Otherwise -> mem[raddr_n].
//  - Both ports may read the same address in the same cycle; both see identical data.
//  - rst asserted mid-sweep or in RUN: the sweep restarts from INIT_FIRST at the next edge.
//  - A write pending in the same cycle as rst is dropped.
//  - sweep_cnt width = clog2(NUM_REGS); it saturates and never wraps into x0.
//  - Register contents survive only until the next reset, which rezeroes them.
// CONFIGURATION
//  - Macro: REGFILE_WRITE_BYPASS_EN.
//  - Defined:
//    - State RUN, we_i=1, waddr_i!=0, waddr_i==raddr_n, re_n=1 -> rdata_n = wdata_i in the same cycle.
//    - Write-first behaviour; decode needs no write-back forwarding path.
//  - Undefined:
//    - The read returns the old mem value; new data is visible from the next cycle.
//    - Write-back forwarding must then be handled by decode.
// STRUCTURE
//  - Shared defines.v supplies:
//    - `RegBus, `RegAddrBus, `ZeroWord, `ZeroRegAddr
//    - `WriteEnable/`WriteDisable, `ReadEnable/`ReadDisable, `RstEnable
//    - new REGFILE_ST_INIT/REGFILE_ST_RUN state encodings
//  - Single module. The sweep FSM is ~20 lines, so no sub-module is warranted.
//  - Storage is a reg array without reset so synthesis can infer distributed RAM.
// TESTING
//  - Reset sweep:
//    - Pulse rst 1 cycle -> init_done_o=0 for exactly 31 cycles, then 1.
//    - Afterwards, reads of x1..x31 all return 32'h0.
//  - Basic write/read:
//    - RUN, write x5=32'hDEADBEEF.
//    - Next cycle re1=1, raddr1=5 -> 32'hDEADBEEF.
//    - re2=0, raddr2=5 -> 32'h0.
//  - x0 protection:
//    - Write x0=32'h12345678.
//    - Read x0 on both ports -> 32'h0, same cycle and later.
//  - Same-cycle write/read, x7 old value 32'h1, writing 32'hA5A5A5A5 while reading x7:
//    - _EN defined -> 32'hA5A5A5A5.
//    - _EN undefined -> 32'h1, then 32'hA5A5A5A5 next cycle.
//  - Write during INIT:
//    - we_i=1, x3=32'hFF at sweep cycle 10 -> ignored.
//    - After init_done_o, x3 reads 32'h0.
//  - Reset mid-operation:
//    - Write x9=32'h55, then assert rst in RUN.
//    - init_done_o drops next edge; reads return 0.
//    - After a fresh 31-cycle sweep, x9 reads 32'h0.

Source files
------------

// File: rtl/stage_regfile_pkg.sv
// -----------------------------------------------------------------------------
// stage_regfile_pkg
// Shared definitions for the integer register file: bus widths, the constant
// encodings used by the decode and write-back stages, and the sweep FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package stage_regfile_pkg;

  // Data and address bus widths.
  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD     = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;

  // Enable encodings shared with the decode and write-back stages.
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  // INIT: post-reset zeroing sweep in progress. RUN: normal operation.
  typedef enum logic {
    REGFILE_ST_INIT = 1'b0,
    REGFILE_ST_RUN  = 1'b1
  } regfile_state_e;

endpackage : stage_regfile_pkg

// File: rtl/stage_regfile.sv
// -----------------------------------------------------------------------------
// stage_regfile
// Integer register file x0..x31 with two combinational read ports for decode
// and one clocked write port for write-back. x0 is hardwired to zero and never
// stored. The storage array has no reset; after every reset a sweep zeroes
// x[INIT_FIRST]..x[NUM_REGS-1], one entry per cycle, so the array can map onto
// distributed LUT-RAM with a single write port.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous, active-high reset
//   we_i         in   1   write enable from write-back
//   waddr_i      in   5   write address
//   wdata_i      in   32  write data
//   re1_i        in   1   read-port-1 enable
//   raddr1_i     in   5   read-port-1 address
//   rdata1_o     out  32  read-port-1 data
//   re2_i        in   1   read-port-2 enable
//   raddr2_i     in   5   read-port-2 address
//   rdata2_o     out  32  read-port-2 data
//   init_done_o  out  1   1 = sweep complete, file usable
//
// Configuration macro: REGFILE_WRITE_BYPASS_EN
//   defined   -> a read of the address being written in the same cycle returns
//                wdata_i (write-first), so decode needs no forwarding path.
//   undefined -> the read returns the stored value; new data appears the next
//                cycle and decode must forward from write-back itself.
// -----------------------------------------------------------------------------
module stage_regfile
  import stage_regfile_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int INIT_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [REG_BUS_W-1:0]  wdata_i,
  input  logic                  re1_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  output logic [REG_BUS_W-1:0]  rdata1_o,
  input  logic                  re2_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [REG_BUS_W-1:0]  rdata2_o,
  output logic                  init_done_o
);

  localparam int               CNT_W     = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(INIT_FIRST);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_REGS - 1);
  localparam int               NUM_PORTS = 2;

  regfile_state_e         state_q, state_d;
  logic [CNT_W-1:0]       sweep_cnt_q, sweep_cnt_d;
  logic                   init_done_q, init_done_d;

  // Storage: deliberately no reset so it infers as distributed RAM.
  logic [REG_BUS_W-1:0]   mem [NUM_REGS];

  logic                   mem_we;
  logic [CNT_W-1:0]       mem_waddr;
  logic [REG_BUS_W-1:0]   mem_wdata;

  logic                   port_re   [NUM_PORTS];
  logic [REG_ADDR_W-1:0]  port_addr [NUM_PORTS];
  logic [REG_BUS_W-1:0]   port_data [NUM_PORTS];

  // ---------------------------------------------------------------------------
  // Control state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= REGFILE_ST_INIT;
      sweep_cnt_q <= FIRST_IDX;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM next state. The counter holds at LAST_IDX rather than wrapping,
  // so the sweep can never reach x0.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      REGFILE_ST_INIT: begin
        if (sweep_cnt_q == LAST_IDX) begin
          state_d     = REGFILE_ST_RUN;
          init_done_d = 1'b1;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end
      REGFILE_ST_RUN: begin
        state_d = REGFILE_ST_RUN;
      end
      default: begin
        state_d = REGFILE_ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single write port shared by the sweep and write-back. Nothing is written
  // while rst is high, so a write coinciding with reset is dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = ZERO_WORD;
    if (rst != RST_ENABLE) begin
      if (state_q == REGFILE_ST_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = sweep_cnt_q;
        mem_wdata = ZERO_WORD;
      end else if ((we_i == WRITE_ENABLE) && (waddr_i != ZERO_REG_ADDR)) begin
        mem_we    = 1'b1;
        mem_waddr = CNT_W'(waddr_i);
        mem_wdata = wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports, identical logic for both.
  // ---------------------------------------------------------------------------
  assign port_re[0]   = re1_i;
  assign port_addr[0] = raddr1_i;
  assign port_re[1]   = re2_i;
  assign port_addr[1] = raddr2_i;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_data[p] = ZERO_WORD;
      if ((rst == RST_ENABLE) || (state_q != REGFILE_ST_RUN)) begin
        port_data[p] = ZERO_WORD;
      end else if (port_re[p] != READ_ENABLE) begin
        port_data[p] = ZERO_WORD;
      end else if (port_addr[p] == ZERO_REG_ADDR) begin
        port_data[p] = ZERO_WORD;
      end
`ifdef REGFILE_WRITE_BYPASS_EN
      else if ((we_i == WRITE_ENABLE) && (waddr_i != ZERO_REG_ADDR) &&
               (waddr_i == port_addr[p])) begin
        port_data[p] = wdata_i;
      end
`endif
      else begin
        port_data[p] = mem[CNT_W'(port_addr[p])];
      end
    end
  end

  assign rdata1_o    = port_data[0];
  assign rdata2_o    = port_data[1];
  assign init_done_o = init_done_q;

endmodule : stage_regfile
